mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: max consecutive data grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 255: max busy cycles without mem_ack before abort; 8-bit counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held with if_addr until if_ack.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetch data, valid while if_ack=1.
REQ-009 dm_req  input  1  data request; held with dm_addr/dm_we/dm_wdata until dm_ack.
REQ-010 dm_we  input  2  write type, 00=load, 01=byte, 10=half, 11=word store.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data, valid while dm_ack=1.
REQ-015 mem_req  output  1  memory access active (registered).
REQ-016 mem_we  output  2  registered write type; 00 for fetch.
REQ-017 mem_addr  output  32  registered address.
REQ-018 mem_wdata  output  32  registered store data; 0 for fetch.
REQ-019 mem_ack  input  1  memory completion pulse, arbitrary wait states (>=1 cycle after mem_req rises).
REQ-020 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-021 bus_err  output  1  one-cycle pulse, coincident with the aborted requester's ack, on timeout.

Function
REQ-022 FSM states IDLE, BUSY_IF, BUSY_DM; shall occupy exactly one state.
REQ-023 IDLE, no request: stay IDLE; mem_req=0.
REQ-024 IDLE, only one req: next state BUSY of that requester; its address/we/wdata latched into mem_* on same edge.
REQ-025 IDLE, both req: grant IF when streak==MAX_STREAK, else grant DM.
REQ-026 streak counter: +1 on DM grant while if_req=1 (saturating at MAX_STREAK); cleared on IF grant or DM grant with if_req=0.
REQ-027 BUSY_x: mem_req=1, mem_* stable; requester input changes ignored.
REQ-028 BUSY_x with mem_ack=1: x_ack=1 combinationally that cycle, x_rdata=mem_rdata; next state IDLE, mem_req=0.
REQ-029 Exactly one IDLE cycle between consecutive transactions; maximum throughput one access per (mem latency+1) cycles.
REQ-030 Timeout counter cleared on grant, +1 each BUSY cycle without mem_ack; when it equals TIMEOUT and mem_ack=0: x_ack=1, x_rdata=0, bus_err=1, next state IDLE.
REQ-031 mem_ack in IDLE shall be ignored (no ack, no error).
REQ-032 if_ack/dm_ack never both 1; if_rdata/dm_rdata=0 whenever own ack=0.
REQ-033 mem_ack and timeout in the same cycle: normal completion, bus_err=0.

Reset
REQ-034 reset=0 immediately forces IDLE, streak=0, timeout counter=0, mem_req=0, mem_we=00, mem_addr=0, mem_wdata=0, acks=0, bus_err=0, regardless of clk.
REQ-035 Reset during BUSY abandons the transaction without ack; first grant possible on first rising edge after reset=1.

Verification
REQ-036 Fetch only, if_addr=0x100, mem_ack 2 cycles after mem_req -> mem_addr=0x100, mem_we=00, if_ack one cycle with if_rdata=mem_rdata, then one IDLE cycle.
REQ-037 Store dm_we=11, dm_addr=0x2000, dm_wdata=0xDEADBEEF while if_req idle -> mem_we=11, mem_wdata=0xDEADBEEF, dm_ack pulse, if_ack stays 0.
REQ-038 if_req and dm_req held continuously, 1-cycle memory -> grant order DM,DM,DM,DM,IF repeating; no IF wait exceeds 4 DM accesses.
REQ-039 mem_ack never returned for fetch -> after 255 busy cycles if_ack=1, if_rdata=0, bus_err=1, mem_req=0 next cycle.
REQ-040 reset pulled low mid BUSY_DM, then mem_ack arrives -> no dm_ack, mem_req=0, all outputs at reset values.
REQ-041 mem_ack on exactly the 255th busy cycle -> normal ack with mem_rdata, bus_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between an instruction-fetch requester and a
// data requester. Data normally wins, but a fetch that has watched MAX_STREAK
// data grants in a row is served next. Every access is guarded by a wait-state
// timeout that aborts the transaction with a bus error.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [1:0]  dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(MAX_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [7:0]    TMO_LIM    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          memReq_q, memReq_d;
  logic [1:0]    memWe_q, memWe_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic [31:0]   memWdata_q, memWdata_d;

  logic busy;
  logic tmoHit;
  logic done;
  logic grantDm;
  logic grantIf;

  // Completion/abort detection for the access in flight and the idle-time grant decision
  always_comb begin
    busy    = (state_q != IDLE);
    tmoHit  = busy && !mem_ack && (tmo_q == TMO_LIM);
    done    = busy && (mem_ack || tmoHit);
    grantDm = (state_q == IDLE) && dm_req && (!if_req || (streak_q != STREAK_LIM));
    grantIf = (state_q == IDLE) && if_req && !grantDm;
  end

  // Next-state values; the memory-side bus is only loaded on a grant so it stays
  // stable for the whole access no matter what the requesters do meanwhile
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    if (grantDm) begin
      state_d    = BUSY_DM;
      memReq_d   = 1'b1;
      memWe_d    = dm_we;
      memAddr_d  = dm_addr;
      memWdata_d = dm_wdata;
      tmo_d      = 8'd0;
      if (!if_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_LIM) begin
        streak_d = streak_q + STREAK_ONE;
      end
    end else if (grantIf) begin
      state_d    = BUSY_IF;
      memReq_d   = 1'b1;
      memWe_d    = 2'b00;
      memAddr_d  = if_addr;
      memWdata_d = 32'd0;
      tmo_d      = 8'd0;
      streak_d   = '0;
    end else if (busy) begin
      if (done) begin
        state_d  = IDLE;
        memReq_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  // Arbiter state and registered memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      tmo_q      <= 8'd0;
      memReq_q   <= 1'b0;
      memWe_q    <= 2'b00;
      memAddr_q  <= 32'd0;
      memWdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Requester acks are combinational from the memory ack so completion costs no extra cycle
  always_comb begin
    if_ack    = done && (state_q == BUSY_IF);
    dm_ack    = done && (state_q == BUSY_DM);
    if_rdata  = (if_ack && mem_ack) ? mem_rdata : 32'd0;
    dm_rdata  = (dm_ack && mem_ack) ? mem_rdata : 32'd0;
    bus_err   = tmoHit;
    mem_req   = memReq_q;
    mem_we    = memWe_q;
    mem_addr  = memAddr_q;
    mem_wdata = memWdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized request/latency traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 255;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [1:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic [1:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks;
  int errors;
  int dmRun;

  mem_port_arbiter #(.MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_if_ack"}, 32'(if_ack), 32'd0);
    checkOutput({tag, "_dm_ack"}, 32'(dm_ack), 32'd0);
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  // Arbitration rule at transaction level: data wins unless the fetch has
  // already watched MAXS data accesses go ahead of it
  function automatic bit pickIf();
    if (if_req && dm_req) return (dmRun >= MAXS);
    return if_req;
  endfunction

  function automatic void noteGrant(input bit wasIf);
    if (wasIf || !if_req) dmRun = 0;
    else dmRun = dmRun + 1;
  endfunction

  // One full access from the grant edge through the following idle cycle.
  // lat = busy cycle on which memory answers; a lat beyond the timeout means never.
  task automatic applyStimulus(input bit expIf, input int lat, input bit scramble);
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [1:0]  eWe;
    logic [31:0] rd;
    bit          fin;
    bit          hit;
    bit          abortNow;
    int          k;
    eAddr  = expIf ? if_addr : dm_addr;
    eWe    = expIf ? 2'b00 : dm_we;
    eWdata = expIf ? 32'd0 : dm_wdata;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput("grant_mem_req", 32'(mem_req), 32'd1);
    checkOutput("grant_mem_addr", mem_addr, eAddr);
    checkOutput("grant_mem_we", 32'(mem_we), 32'(eWe));
    checkOutput("grant_mem_wdata", mem_wdata, eWdata);
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      k++;
      rd = $urandom;
      hit = (k == lat);
      abortNow = !hit && (k == TMO + 1);
      mem_ack = hit;
      mem_rdata = rd;
      if (scramble) begin
        if (expIf) if_addr = $urandom;
        else begin
          dm_addr  = $urandom;
          dm_wdata = $urandom;
          dm_we    = 2'($urandom);
        end
      end
      @(negedge clk);
      checkOutput("busy_if_ack", 32'(if_ack), 32'(expIf && (hit || abortNow)));
      checkOutput("busy_dm_ack", 32'(dm_ack), 32'(!expIf && (hit || abortNow)));
      checkOutput("busy_if_rdata", if_rdata, (expIf && hit) ? rd : 32'd0);
      checkOutput("busy_dm_rdata", dm_rdata, (!expIf && hit) ? rd : 32'd0);
      checkOutput("busy_bus_err", 32'(bus_err), 32'(abortNow));
      checkOutput("busy_mem_req", 32'(mem_req), 32'd1);
      checkOutput("busy_mem_addr", mem_addr, eAddr);
      checkOutput("busy_mem_wdata", mem_wdata, eWdata);
      fin = hit || abortNow;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    checkOutput("post_idle_mem_req", 32'(mem_req), 32'd0);
  endtask

  // An idle cycle with a stray memory ack that must be ignored
  task automatic idleStray();
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    checkOutput("stray_if_ack", 32'(if_ack), 32'd0);
    checkOutput("stray_dm_ack", 32'(dm_ack), 32'd0);
    checkOutput("stray_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("stray_mem_req", 32'(mem_req), 32'd0);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    bit expIf;
    checks    = 0;
    errors    = 0;
    dmRun     = 0;
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'd0;
    dm_req    = 1'b0;
    dm_we     = 2'b00;
    dm_addr   = 32'd0;
    dm_wdata  = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;

    #3;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    idleStray();

    $display("[TB] fetch with two-cycle memory");
    if_req = 1'b1;
    if_addr = 32'h100;
    noteGrant(1'b1);
    applyStimulus(1'b1, 2, 1'b0);
    if_req = 1'b0;

    $display("[TB] word store");
    dm_req = 1'b1;
    dm_we = 2'b11;
    dm_addr = 32'h2000;
    dm_wdata = 32'hDEADBEEF;
    noteGrant(1'b0);
    applyStimulus(1'b0, 1, 1'b0);
    dm_req = 1'b0;

    $display("[TB] both requesters held, single-cycle memory");
    if_req = 1'b1;
    if_addr = 32'h4000;
    dm_req = 1'b1;
    dm_we = 2'b00;
    dm_addr = 32'h8000;
    dm_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 5) == 4, 1, 1'b0);
      if ((i % 5) == 4) if_addr = if_addr + 32'd4;
      else dm_addr = dm_addr + 32'd4;
    end
    dmRun = 0;
    if_req = 1'b0;
    dm_req = 1'b0;

    $display("[TB] fetch timeout");
    if_req = 1'b1;
    if_addr = 32'h300;
    noteGrant(1'b1);
    applyStimulus(1'b1, 10000, 1'b0);

    $display("[TB] ack on the last allowed busy cycle and on the timeout cycle");
    noteGrant(1'b1);
    applyStimulus(1'b1, TMO, 1'b0);
    noteGrant(1'b1);
    applyStimulus(1'b1, TMO + 1, 1'b0);
    if_req = 1'b0;

    $display("[TB] data timeout with changing inputs");
    dm_req = 1'b1;
    dm_we = 2'b01;
    dm_addr = 32'h1234;
    dm_wdata = 32'h55;
    noteGrant(1'b0);
    applyStimulus(1'b0, 10000, 1'b1);
    dm_req = 1'b0;

    $display("[TB] reset during data access");
    dm_req = 1'b1;
    dm_we = 2'b10;
    dm_addr = 32'h7770;
    dm_wdata = 32'hCAFE;
    @(posedge clk); #1;
    checkOutput("rst_grant_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("rst_async");
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    #1;
    checkOutput("rst_ack_dm_ack", 32'(dm_ack), 32'd0);
    checkOutput("rst_ack_dm_rdata", dm_rdata, 32'd0);
    checkOutput("rst_ack_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    checkResetOutputs("rst_held");
    mem_ack = 1'b0;
    reset = 1'b1;
    dmRun = 0;
    dm_addr = 32'h7780;
    noteGrant(1'b0);
    applyStimulus(1'b0, 3, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      if (!if_req && ($urandom % 2 == 0)) begin
        if_req = 1'b1;
        if_addr = $urandom;
      end
      if (!dm_req && ($urandom % 2 == 0)) begin
        dm_req = 1'b1;
        dm_we = 2'($urandom);
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      if (!if_req && !dm_req) begin
        idleStray();
      end else begin
        expIf = pickIf();
        noteGrant(expIf);
        applyStimulus(expIf, int'($urandom_range(1, 6)), 1'($urandom % 2));
        if ($urandom % 2 == 0) begin
          if (expIf) if_req = 1'b0;
          else dm_req = 1'b0;
        end else if (expIf) begin
          if_addr = $urandom;
        end else begin
          dm_we = 2'($urandom);
          dm_addr = $urandom;
          dm_wdata = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
